lzc_norm_pipe: RTL

LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

---
 rtl/lzc_norm_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading zero/one counter with optional normalising shift.
// Stage 1 counts per byte group; stage 2 merges group counts and shifts.
// Optional feature macro: LZC_NORM_SHIFT_EN (enables out_norm barrel shift).
module lzc_norm_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAGW  = 8,
  localparam int unsigned CW   = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ones,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAGW-1:0]  out_tag
);

  localparam int unsigned NG = WIDTH / 8;

  // Leading zero count of one byte, 0..8.
  function automatic logic [3:0] lzc8(input logic [7:0] b);
    logic [3:0] c;
    c = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) c = 4'(7 - i);
    end
    return c;
  endfunction

  logic [WIDTH-1:0]     w_inv;
  logic [NG-1:0][3:0]   w_grp_cnt;
  logic                 w_all_zero;
  logic [CW-1:0]        w_cnt;
  logic                 w_ld2;

  logic                 r_s1_v;
  logic [NG-1:0][3:0]   r_s1_cnt;
  logic                 r_s1_zero;
  logic [TAGW-1:0]      r_s1_tag;
`ifdef LZC_NORM_SHIFT_EN
  logic [WIDTH-1:0]     r_s1_data;
  logic [WIDTH-1:0]     r_out_norm;
`endif

  logic                 r_out_valid;
  logic [CW-1:0]        r_out_count;
  logic                 r_out_zero;
  logic [TAGW-1:0]      r_out_tag;

  // Handshake: stage 2 frees when empty or drained; stage 1 frees when stage 2 can take it.
  assign w_ld2    = !r_out_valid || out_ready;
  assign in_ready = !r_s1_v || w_ld2;

  // Stage 1 combinational: optional inversion, per-group counts, all-zero detect.
  always_comb begin
    w_inv = in_ones ? ~in_data : in_data;
    w_grp_cnt = '0;
    for (int g = 0; g < int'(NG); g++) begin
      // Group 0 is the most significant byte.
      w_grp_cnt[g] = lzc8(w_inv[WIDTH-1-8*g -: 8]);
    end
    w_all_zero = (w_inv == '0);
  end

  // Stage 1 register: loads whenever the pipe can accept.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_v    <= 1'b0;
      r_s1_cnt  <= '0;
      r_s1_zero <= 1'b0;
      r_s1_tag  <= '0;
`ifdef LZC_NORM_SHIFT_EN
      r_s1_data <= '0;
`endif
    end else if (in_ready) begin
      r_s1_v    <= in_valid;
      r_s1_cnt  <= w_grp_cnt;
      r_s1_zero <= w_all_zero;
      r_s1_tag  <= in_tag;
`ifdef LZC_NORM_SHIFT_EN
      r_s1_data <= in_data;
`endif
    end
  end

  // Stage 2 combinational: 8 * leading empty groups + count of first non-empty group.
  always_comb begin
    w_cnt = CW'(WIDTH);
    // Walk from least to most significant so the first non-empty group wins.
    for (int g = int'(NG) - 1; g >= 0; g--) begin
      if (r_s1_cnt[g] != 4'd8) w_cnt = CW'(8 * g) + CW'(r_s1_cnt[g]);
    end
  end

  // Stage 2 register: result outputs, held while the consumer stalls.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_zero  <= 1'b0;
      r_out_tag   <= '0;
`ifdef LZC_NORM_SHIFT_EN
      r_out_norm  <= '0;
`endif
    end else if (w_ld2) begin
      r_out_valid <= r_s1_v;
      r_out_count <= w_cnt;
      r_out_zero  <= r_s1_zero;
      r_out_tag   <= r_s1_tag;
`ifdef LZC_NORM_SHIFT_EN
      // Shift amount WIDTH yields zero, covering the all-zero operand.
      r_out_norm  <= r_s1_data << w_cnt;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_zero  = r_out_zero;
  assign out_tag   = r_out_tag;
`ifdef LZC_NORM_SHIFT_EN
  assign out_norm  = r_out_norm;
`else
  assign out_norm  = '0;
`endif

endmodule
